// File: rtl/voxel_scene_streamer.sv
// Serialises packed occupancy words from the host FIFO into one-bit voxel writes
// for raytracer_top, in ascending {z,y,x} address order.
module voxel_scene_streamer #(
  parameter int ADDR_BITS = 15,
  parameter int WORD_W    = 32,
  parameter int SETTLE    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  input  logic                 word_valid,
  output logic                 word_ready,
  input  logic [WORD_W-1:0]    word_data,
  output logic                 load_mode,
  output logic                 load_valid,
  input  logic                 load_ready,
  output logic [ADDR_BITS-1:0] load_addr,
  output logic                 load_data,
  output logic [ADDR_BITS:0]   voxels_sent
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [ADDR_BITS:0]   LAST_ADDR = {1'b0, {ADDR_BITS{1'b1}}};
  localparam logic [BIT_W-1:0]     LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [SET_W-1:0]     LAST_SET  = SET_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t              state_reg;
  logic [ADDR_BITS:0]  addr_reg;
  logic [WORD_W-1:0]   shift_reg;
  logic [WORD_W-1:0]   shift_next;
  logic [BIT_W-1:0]    bitcnt_reg;
  logic [SET_W-1:0]    settle_reg;

  assign shift_next = shift_reg >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      addr_reg    <= '0;
      shift_reg   <= '0;
      bitcnt_reg  <= '0;
      settle_reg  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      word_ready  <= 1'b0;
      load_mode   <= 1'b0;
      load_valid  <= 1'b0;
      load_addr   <= '0;
      load_data   <= 1'b0;
      voxels_sent <= '0;
    end else begin
      done <= 1'b0;
      if (abort && busy) begin
        // A write handshaking in the abort cycle still happened downstream, so count it.
        if (load_valid && load_ready)
          voxels_sent <= voxels_sent + 1'b1;
        state_reg  <= S_IDLE;
        busy       <= 1'b0;
        word_ready <= 1'b0;
        load_mode  <= 1'b0;
        load_valid <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start && !abort) begin
              addr_reg    <= '0;
              voxels_sent <= '0;
              busy        <= 1'b1;
              load_mode   <= 1'b1;
              word_ready  <= 1'b1;
              state_reg   <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (word_valid && word_ready) begin
              shift_reg  <= word_data;
              bitcnt_reg <= '0;
              word_ready <= 1'b0;
              load_valid <= 1'b1;
              load_addr  <= addr_reg[ADDR_BITS-1:0];
              load_data  <= word_data[0];
              state_reg  <= S_SEND;
            end
          end
          S_SEND: begin
            if (load_valid && load_ready) begin
              addr_reg    <= addr_reg + 1'b1;
              shift_reg   <= shift_next;
              bitcnt_reg  <= bitcnt_reg + 1'b1;
              voxels_sent <= voxels_sent + 1'b1;
              // Terminal test uses the accepted address, before the increment.
              if (addr_reg == LAST_ADDR) begin
                load_valid <= 1'b0;
                settle_reg <= '0;
                state_reg  <= S_SETTLE;
              end else if (bitcnt_reg == LAST_BIT) begin
                load_valid <= 1'b0;
                word_ready <= 1'b1;
                state_reg  <= S_FETCH;
              end else begin
                load_addr <= addr_reg[ADDR_BITS-1:0] + 1'b1;
                load_data <= shift_next[0];
              end
            end
          end
          S_SETTLE: begin
            if (settle_reg == LAST_SET) begin
              load_mode <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              settle_reg <= settle_reg + 1'b1;
            end
          end
          S_DONE: begin
            state_reg <= S_IDLE;
          end
          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voxel_scene_streamer.sv
// Randomised bench for voxel_scene_streamer: a packed scene model and a write
// scoreboard check ordering, data, stall stability, abort and reset behaviour.
module tb_voxel_scene_streamer;

  localparam int AB = 10;
  localparam int WW = 32;
  localparam int ST = 10;
  localparam int N  = 1 << AB;
  localparam int NW = N / WW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, word_ready, load_mode, load_valid, load_data;
  logic          word_valid = 1'b0;
  logic [WW-1:0] word_data = '0;
  logic          load_ready = 1'b0;
  logic [AB-1:0] load_addr;
  logic [AB:0]   voxels_sent;

  voxel_scene_streamer #(.ADDR_BITS(AB), .WORD_W(WW), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .load_mode(load_mode), .load_valid(load_valid), .load_ready(load_ready),
    .load_addr(load_addr), .load_data(load_data), .voxels_sent(voxels_sent)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Scene model and environment controls
  logic [N-1:0] scene;
  int  ready_mode = 3;   // 0 tied high, 1 toggle, 2 random, 3 manual
  int  gap_cycles = 0;
  bit  host_en = 0;
  bit  mon_en = 0;
  int  host_idx, gap_left;
  bit  hs_pend;
  int  cyc = 0;
  int  start_cyc;

  // Scoreboard state
  int  exp_idx, seq_err, data_err, stab_err, mode_err, ones, one_addr;
  int  done_cnt, done_cyc, last_wr_cyc;
  bit  prev_stall;
  logic [AB-1:0] prev_addr;
  logic          prev_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Host FIFO and downstream ready drivers
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: load_ready = 1'b1;
      1: load_ready = ~load_ready;
      2: load_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
    if (hs_pend) begin
      hs_pend    = 0;
      host_idx++;
      word_valid = 1'b0;
      gap_left   = gap_cycles;
    end else if (host_en && host_idx < NW) begin
      if (gap_left > 0) gap_left--;
      else begin
        word_valid = 1'b1;
        word_data  = scene[host_idx*WW +: WW];
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid && word_ready) hs_pend = 1;
      if (mon_en) begin
        if (load_valid && load_ready) begin
          if (exp_idx >= N || load_addr != AB'(exp_idx)) seq_err++;
          else if (load_data != scene[exp_idx]) data_err++;
          if (load_data) begin
            ones++;
            one_addr = int'(load_addr);
          end
          exp_idx++;
          last_wr_cyc = cyc;
        end
        if (prev_stall && (!load_valid || load_addr != prev_addr || load_data != prev_data))
          stab_err++;
        prev_stall = load_valid && !load_ready;
        prev_addr  = load_addr;
        prev_data  = load_data;
        if (busy && !load_mode) mode_err++;
        if (load_valid && word_ready) mode_err++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          if (busy) mode_err++;
        end
      end
    end
  end

  task automatic random_scene();
    for (int i = 0; i < N; i += 32) scene[i +: 32] = $urandom;
  endtask

  task automatic begin_load(input int mode, input int gap);
    @(posedge clk);
    #2;
    ready_mode = mode;
    gap_cycles = gap;
    host_idx = 0; gap_left = 0; hs_pend = 0;
    word_valid = 1'b0;
    exp_idx = 0; seq_err = 0; data_err = 0; stab_err = 0; mode_err = 0;
    ones = 0; one_addr = -1; done_cnt = 0; done_cyc = 0; last_wr_cyc = 0;
    prev_stall = 0;
    mon_en = 1; host_en = 1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    for (int i = 0; i < limit && done_cnt == 0; i++) @(posedge clk);
    chk({name, "/done_seen"}, done_cnt, 1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic finish_checks(input string name, input bit timing);
    chk({name, "/order"}, seq_err, 0);
    chk({name, "/data"}, data_err, 0);
    chk({name, "/writes"}, exp_idx, N);
    chk({name, "/voxels_sent"}, voxels_sent, N);
    chk({name, "/done_once"}, done_cnt, 1);
    chk({name, "/stable"}, stab_err, 0);
    chk({name, "/mode"}, mode_err, 0);
    chk({name, "/ones"}, ones, $countones(scene));
    chk({name, "/settle"}, done_cyc - last_wr_cyc, ST + 1);
    chk({name, "/idle_busy"}, busy, 0);
    if (timing) chk({name, "/latency"}, done_cyc - start_cyc, NW*(WW+1) + ST + 1);
    $display("load %s: writes=%0d ones=%0d cycles=%0d", name, exp_idx, ones, done_cyc - start_cyc);
  endtask

  task automatic wait_addr(input int a, output bit found);
    found = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (load_valid && load_addr == AB'(a)) begin
        found = 1;
        return;
      end
    end
  endtask

  bit found;
  int partial;

  initial begin
    // Reset with random inputs
    repeat (5) begin
      @(posedge clk);
      #1;
      start = 1'($urandom); abort = 1'($urandom); word_valid = 1'($urandom);
      word_data = $urandom; load_ready = 1'($urandom);
    end
    @(negedge clk);
    chk("rst/outputs", {busy, done, word_ready, load_mode, load_valid, load_addr, load_data, voxels_sent}, 0);
    chk("rst/word_ready", word_ready, 0);
    chk("rst/busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; abort = 1'b0; word_valid = 1'b0;
    $display("reset: outputs cleared");

    // Single occupied voxel, no stalls
    scene = '0;
    scene[20*WW + 15] = 1'b1;
    begin_load(0, 0);
    wait_done("single", NW*(WW+1) + 200);
    finish_checks("single", 1);
    chk("single/one_addr", one_addr, 20*WW + 15);

    random_scene();
    begin_load(0, 0);
    wait_done("rand_full", NW*(WW+1) + 200);
    finish_checks("rand_full", 1);

    // Backpressure
    random_scene();
    begin_load(1, 0);
    wait_done("toggle_ready", 3*NW*(WW+1) + 200);
    finish_checks("toggle_ready", 0);

    random_scene();
    begin_load(2, 0);
    wait_done("random_ready", 4*NW*(WW+1) + 200);
    finish_checks("random_ready", 0);

    // Source gaps
    random_scene();
    begin_load(0, 20);
    wait_done("gaps", NW*(WW+22) + 200);
    finish_checks("gaps", 0);

    // Abort at address 1000
    random_scene();
    begin_load(2, 0);
    wait_addr(1000, found);
    chk("abort/reach", found, 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    partial = exp_idx;
    host_en = 0;
    @(negedge clk);
    chk("abort/load_valid", load_valid, 0);
    chk("abort/load_mode", load_mode, 0);
    chk("abort/busy", busy, 0);
    chk("abort/word_ready", word_ready, 0);
    chk("abort/partial", voxels_sent, partial);
    repeat (30) @(posedge clk);
    #1;
    chk("abort/no_done", done_cnt, 0);
    chk("abort/hold", voxels_sent, partial);
    $display("load abort: stopped after %0d writes", partial);
    begin_load(0, 0);
    wait_done("after_abort", NW*(WW+1) + 200);
    finish_checks("after_abort", 1);

    // Start while busy is ignored
    random_scene();
    begin_load(1, 0);
    wait_addr(200, found);
    chk("start_busy/reach", found, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("start_busy", 3*NW*(WW+1) + 200);
    finish_checks("start_busy", 0);

    // Mid-load reset
    random_scene();
    begin_load(0, 0);
    wait_addr(500, found);
    chk("midrst/reach", found, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; host_en = 0; mon_en = 0; word_valid = 1'b0;
    chk("midrst/outputs", {busy, done, word_ready, load_mode, load_valid, load_addr, load_data, voxels_sent}, 0);
    $display("load midrst: reset applied mid-load");
    random_scene();
    begin_load(2, 0);
    wait_done("after_rst", 4*NW*(WW+1) + 200);
    finish_checks("after_rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
